// File: rtl/add_result_stage.sv
// Result stage after the carry-lookahead adder: captures sum/cout, derives Z/N/C/V,
// buffers up to two beats (main + skid), and keeps a saturating signed-overflow count.
`timescale 1ns/1ps
module add_result_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:WIDTH-1] in_sum,
    input  logic             in_cout,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] out_result,
    output logic             out_c,
    output logic             out_z,
    output logic             out_n,
    output logic             out_v,
    input  logic             clr_count,
    output logic [CNT_W-1:0] ovf_count
);

    typedef struct packed {
        logic [0:WIDTH-1] sum;
        logic             c;
        logic             z;
        logic             n;
        logic             v;
    } beat_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    beat_t            main_q, main_d;
    beat_t            skid_q, skid_d;
    beat_t            in_beat_c;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept_c;
    logic             produce_c;

    // Flags are derived from the incoming beat and travel with it through the buffer.
    always_comb begin
        in_beat_c.sum = in_sum;
        in_beat_c.c   = in_cout;
        in_beat_c.z   = ~|in_sum;
        in_beat_c.n   = in_sum[WIDTH-1];
        in_beat_c.v   = (in_a_msb == in_b_msb) & (in_sum[WIDTH-1] != in_a_msb);
    end

    assign accept_c  = in_valid & in_ready_q;
    assign produce_c = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    main_d  = in_beat_c;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept_c && produce_c) begin
                    main_d = in_beat_c;
                end else if (accept_c) begin
                    skid_d  = in_beat_c;
                    state_d = ST_TWO;
                end else if (produce_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (produce_c) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Ready and valid are flopped from the next occupancy, so out_ready never reaches in_ready combinationally.
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
        if (clr_count) begin
            cnt_d = '0;
        end else if (accept_c && in_beat_c.v && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = main_q.sum;
    assign out_c      = main_q.c;
    assign out_z      = main_q.z;
    assign out_n      = main_q.n;
    assign out_v      = main_q.v;
    assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_add_result_stage.sv
// Bench for add_result_stage: queue model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_add_result_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [0:7] in_sum;
    logic       in_cout, in_a_msb, in_b_msb;
    logic       out_valid, out_ready;
    logic [0:7] out_result;
    logic       out_c, out_z, out_n, out_v;
    logic       clr_count;
    logic [7:0] ovf_count;

    int checks   = 0;
    int failures = 0;

    add_result_stage #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_c(out_c), .out_z(out_z), .out_n(out_n), .out_v(out_v),
        .clr_count(clr_count), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    // Index i of the port vector carries numeric bit i (index 0 = LSB).
    function automatic logic [0:7] to_bits(input logic [7:0] v);
        logic [0:7] b;
        for (int i = 0; i < 8; i++) b[i] = v[i];
        return b;
    endfunction

    function automatic logic [7:0] from_bits(input logic [0:7] b);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = b[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a two-deep FIFO of beats with flags from plain arithmetic, and an integer counter.
    typedef struct {
        logic [7:0] val;
        logic c, z, n, v;
    } mbeat_t;

    mbeat_t q[$];
    int     m_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            bit     acc, prd;
            mbeat_t nb;
            acc    = in_valid && (q.size() < 2);
            prd    = (q.size() > 0) && out_ready;
            nb.val = from_bits(in_sum);
            nb.c   = in_cout;
            nb.z   = (nb.val == 8'd0);
            nb.n   = (nb.val >= 8'd128);
            nb.v   = (in_a_msb == in_b_msb) && ((nb.val >= 8'd128) != in_a_msb);
            if (prd) void'(q.pop_front());
            if (acc) q.push_back(nb);
            if (clr_count) m_cnt = 0;
            else if (acc && nb.v && m_cnt < 255) m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("m_ovf_count", 32'(ovf_count), 32'(m_cnt));
            if (q.size() > 0) begin
                chk("m_result", 32'(from_bits(out_result)), 32'(q[0].val));
                chk("m_flags", {28'd0, out_c, out_z, out_n, out_v},
                    {28'd0, q[0].c, q[0].z, q[0].n, q[0].v});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] v, input logic c, input logic a, input logic b);
        in_valid = 1'b1;
        in_sum   = to_bits(v);
        in_cout  = c;
        in_a_msb = a;
        in_b_msb = b;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0;
        in_a_msb = 1'b0; in_b_msb = 1'b0; out_ready = 1'b0; clr_count = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(ovf_count), 32'd0);
        chk("rst_result", 32'(from_bits(out_result)), 32'd0);
        chk("rst_flags", {28'd0, out_c, out_z, out_n, out_v}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single zero-sum beat with carry
        out_ready = 1'b1;
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_result", 32'(from_bits(out_result)), 32'h00);
        chk("t1_flags_czn_v", {28'd0, out_c, out_z, out_n, out_v}, 32'b1100);
        tick();
        chk("t1_drained", 32'(out_valid), 32'd0);

        // Signed overflow in both directions
        drive(8'h80, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t2_n_v", {30'd0, out_n, out_v}, 32'b11);
        chk("t2_count1", 32'(ovf_count), 32'd1);
        drive(8'h7F, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        chk("t2_v", 32'(out_v), 32'd1);
        chk("t2_count2", 32'(ovf_count), 32'd2);
        tick();

        // Backpressure fills main and skid; third beat waits upstream
        out_ready = 1'b0;
        drive(8'h11, 1'b0, 1'b0, 1'b0);
        tick();
        drive(8'h22, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t3_full", 32'(in_ready), 32'd0);
        drive(8'h33, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("t3_still_full", 32'(in_ready), 32'd0);
        chk("t3_hold11", 32'(from_bits(out_result)), 32'h11);
        out_ready = 1'b1;
        tick();
        chk("t3_out22", 32'(from_bits(out_result)), 32'h22);
        tick();
        idle();
        chk("t3_out33", 32'(from_bits(out_result)), 32'h33);
        tick();
        chk("t3_drained", 32'(out_valid), 32'd0);

        // Streaming at one beat per cycle
        for (int i = 0; i < 20; i++) begin
            drive(8'(i), 1'b0, 1'b0, 1'b0);
            tick();
            chk("t4_ready", 32'(in_ready), 32'd1);
            chk("t4_result", 32'(from_bits(out_result)), 32'(i));
        end
        idle();
        tick();

        // Saturation, then clear beats a simultaneous increment
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        chk("t5_cleared", 32'(ovf_count), 32'd0);
        for (int i = 0; i < 300; i++) begin
            drive(8'h80, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        chk("t5_saturated", 32'(ovf_count), 32'd255);
        drive(8'h80, 1'b0, 1'b0, 1'b0);
        clr_count = 1'b1;
        tick();
        idle();
        clr_count = 1'b0;
        chk("t5_clear_wins", 32'(ovf_count), 32'd0);
        tick();

        // Asynchronous reset while full
        out_ready = 1'b0;
        drive(8'h80, 1'b0, 1'b0, 1'b0);
        tick();
        drive(8'h02, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("t6_full", 32'(in_ready), 32'd0);
        chk("t6_count", 32'(ovf_count), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_count", 32'(ovf_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        drive(8'h05, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("t6_resume_valid", 32'(out_valid), 32'd1);
        chk("t6_resume_result", 32'(from_bits(out_result)), 32'h05);
        tick();
        chk("t6_resume_drained", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
